trap_ctrl: RTL and testbench

TRAP_CTRL -- requirements
Module: trap_ctrl

---
 rtl/trap_ctrl_pkg.sv | 33 +++
 rtl/trap_ctrl_if.sv | 34 +++
 rtl/trap_ctrl_prio_enc.sv | 35 +++
 rtl/trap_ctrl.sv | 118 +++++++++++
 tb/tb_trap_ctrl.sv | 167 ++++++++++++++++
 5 files changed

// File: rtl/trap_ctrl_pkg.sv
// Shared definitions for the trap controller: FSM state encoding,
// exception-vector bit positions and the architectural cause codes.
package trap_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ENTER   = 3'd1,
    ST_HANDLER = 3'd2,
    ST_RETURN  = 3'd3,
    ST_HALT    = 3'd4
  } trap_state_t;

  localparam int EXC_W = 7;

  // Bit positions inside exceptSignal
  localparam int EXC_RD_MIS = 0;
  localparam int EXC_RD_AF  = 1;
  localparam int EXC_WR_MIS = 2;
  localparam int EXC_WR_AF  = 3;
  localparam int EXC_RD_PF  = 4;
  localparam int EXC_WR_PF  = 5;
  localparam int EXC_BRK    = 6;

  // Cause codes reported in the cause register
  localparam logic [4:0] CAUSE_BRK    = 5'd3;
  localparam logic [4:0] CAUSE_RD_MIS = 5'd4;
  localparam logic [4:0] CAUSE_RD_AF  = 5'd5;
  localparam logic [4:0] CAUSE_WR_MIS = 5'd6;
  localparam logic [4:0] CAUSE_WR_AF  = 5'd7;
  localparam logic [4:0] CAUSE_RD_PF  = 5'd13;
  localparam logic [4:0] CAUSE_WR_PF  = 5'd15;

endpackage

// File: rtl/trap_ctrl_if.sv
// Pipeline <-> trap controller interface.
//   master : pipeline side, drives E-stage exception info and eret,
//            consumes flush / redirect / trap CSR values.
//   slave  : trap controller side.
interface trap_ctrl_if #(
  parameter int N = 64
) ();

  logic [6:0]   exceptSignal;
  logic         valid_E;
  logic [N-1:0] PC_E;
  logic [N-1:0] DM_addr;
  logic         eret;

  logic         flush;
  logic         redirect_en;
  logic [N-1:0] redirect_pc;
  logic [N-1:0] epc;
  logic [N-1:0] tval;
  logic [4:0]   cause;
  logic         in_handler;
  logic         halted;

  modport master (
    output exceptSignal, valid_E, PC_E, DM_addr, eret,
    input  flush, redirect_en, redirect_pc, epc, tval, cause, in_handler, halted
  );

  modport slave (
    input  exceptSignal, valid_E, PC_E, DM_addr, eret,
    output flush, redirect_en, redirect_pc, epc, tval, cause, in_handler, halted
  );

endinterface

// File: rtl/trap_ctrl_prio_enc.sv
// Exception priority encoder (purely combinational).
//   exc         : E-stage exception vector
//   cause       : cause code of the highest-priority set bit (0 if none)
//   tval_sel_pc : 1 when tval must come from PC_E (breakpoint) rather than DM_addr
module trap_prio_enc
  import trap_ctrl_pkg::*;
(
  input  logic [EXC_W-1:0] exc,
  output logic [4:0]       cause,
  output logic             tval_sel_pc
);

  // Breakpoint first, then misaligns, then page faults, then access faults.
  always_comb begin
    cause       = 5'd0;
    tval_sel_pc = 1'b0;
    if (exc[EXC_BRK]) begin
      cause       = CAUSE_BRK;
      tval_sel_pc = 1'b1;
    end else if (exc[EXC_WR_MIS]) begin
      cause = CAUSE_WR_MIS;
    end else if (exc[EXC_RD_MIS]) begin
      cause = CAUSE_RD_MIS;
    end else if (exc[EXC_WR_PF]) begin
      cause = CAUSE_WR_PF;
    end else if (exc[EXC_RD_PF]) begin
      cause = CAUSE_RD_PF;
    end else if (exc[EXC_WR_AF]) begin
      cause = CAUSE_WR_AF;
    end else if (exc[EXC_RD_AF]) begin
      cause = CAUSE_RD_AF;
    end
  end

endmodule

// File: rtl/trap_ctrl.sv
// Trap controller: takes E-stage exceptions, squashes the pipeline,
// redirects fetch to the handler, returns on eret and halts on a
// fault taken while already in the handler.
//   clk   : clock, rising edge
//   reset : synchronous, active-high
//   tif   : slave side of trap_ctrl_if (exception inputs, flush/redirect/CSR outputs)
module trap_ctrl
  import trap_ctrl_pkg::*;
#(
  parameter int           N           = 64,
  parameter logic [N-1:0] TRAP_VECTOR = N'(64'h0000_0000_0000_0100)
) (
  input  logic        clk,
  input  logic        reset,
  trap_ctrl_if.slave  tif
);

  trap_state_t  state_q, state_d;
  logic [N-1:0] epc_q, epc_d;
  logic [N-1:0] tval_q, tval_d;
  logic [4:0]   cause_q, cause_d;
  logic         redirect_en_q, redirect_en_d;
  logic [N-1:0] redirect_pc_q, redirect_pc_d;
  logic         in_handler_q, in_handler_d;
  logic         halted_q, halted_d;
  logic         flush;

  logic         req;
  logic [4:0]   enc_cause;
  logic         enc_sel_pc;

  assign req = tif.valid_E && (|tif.exceptSignal);

  trap_prio_enc u_prio_enc (
    .exc         (tif.exceptSignal),
    .cause       (enc_cause),
    .tval_sel_pc (enc_sel_pc)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      epc_q         <= '0;
      tval_q        <= '0;
      cause_q       <= '0;
      redirect_en_q <= 1'b0;
      redirect_pc_q <= '0;
      in_handler_q  <= 1'b0;
      halted_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      epc_q         <= epc_d;
      tval_q        <= tval_d;
      cause_q       <= cause_d;
      redirect_en_q <= redirect_en_d;
      redirect_pc_q <= redirect_pc_d;
      in_handler_q  <= in_handler_d;
      halted_q      <= halted_d;
    end
  end

  // A request in HANDLER beats a simultaneous eret: it is a double fault.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:    if (req) state_d = ST_ENTER;
      ST_ENTER:   state_d = ST_HANDLER;
      ST_HANDLER: begin
        if (req)           state_d = ST_HALT;
        else if (tif.eret) state_d = ST_RETURN;
      end
      ST_RETURN:  state_d = ST_IDLE;
      ST_HALT:    state_d = ST_HALT;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Registered outputs are decoded from the next state so they line up
  // with the state they describe; only flush reacts within the cycle.
  always_comb begin
    epc_d   = epc_q;
    tval_d  = tval_q;
    cause_d = cause_q;
    if (state_q == ST_IDLE && req) begin
      epc_d   = tif.PC_E;
      cause_d = enc_cause;
      tval_d  = enc_sel_pc ? tif.PC_E : tif.DM_addr;
    end

    redirect_en_d = (state_d == ST_ENTER) || (state_d == ST_RETURN);
    redirect_pc_d = '0;
    if (state_d == ST_ENTER) begin
      redirect_pc_d = TRAP_VECTOR;
    end else if (state_d == ST_RETURN) begin
      // Breakpoint resumes past the trapping instruction; wraps modulo 2^N.
      redirect_pc_d = (cause_q == CAUSE_BRK) ? (epc_q + N'(4)) : epc_q;
    end

    in_handler_d = (state_d == ST_HANDLER) || (state_d == ST_RETURN) ||
                   (state_d == ST_HALT);
    halted_d     = (state_d == ST_HALT);

    // Combinational so the faulting store is suppressed in its own cycle.
    flush = !reset &&
            ((state_q == ST_ENTER) || (state_q == ST_RETURN) || (state_q == ST_HALT) ||
             (((state_q == ST_IDLE) || (state_q == ST_HANDLER)) && req));
  end

  assign tif.flush       = flush;
  assign tif.redirect_en = redirect_en_q;
  assign tif.redirect_pc = redirect_pc_q;
  assign tif.epc         = epc_q;
  assign tif.tval        = tval_q;
  assign tif.cause       = cause_q;
  assign tif.in_handler  = in_handler_q;
  assign tif.halted      = halted_q;

endmodule

// File: tb/tb_trap_ctrl.sv
module tb_trap_ctrl;

  localparam logic [63:0] TV = 64'h100;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  trap_ctrl_if #(.N(64)) tif ();

  trap_ctrl #(.N(64), .TRAP_VECTOR(TV)) dut (
    .clk   (clk),
    .reset (reset),
    .tif   (tif.slave)
  );

  typedef struct packed {
    logic        flush;
    logic        ren;
    logic [63:0] rpc;
    logic        inh;
    logic        halt;
    logic [63:0] epc;
    logic [4:0]  cause;
    logic [63:0] tval;
  } obs_t;

  obs_t sb_q[$];
  int   tag_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   vec      = 0;

  function automatic obs_t mk(input logic f, input logic ren, input logic [63:0] rpc,
                              input logic inh, input logic halt, input logic [63:0] epc,
                              input logic [4:0] cause, input logic [63:0] tval);
    obs_t o;
    o.flush = f;   o.ren  = ren;  o.rpc   = rpc;   o.inh  = inh;
    o.halt  = halt; o.epc = epc;  o.cause = cause; o.tval = tval;
    return o;
  endfunction

  // Drive one cycle of inputs and queue the outputs expected during it.
  task automatic cyc(input logic r, input logic v, input logic [6:0] ex,
                     input logic [63:0] pc, input logic [63:0] addr,
                     input logic er, input obs_t e);
    @(posedge clk);
    #1;
    reset            = r;
    tif.valid_E      = v;
    tif.exceptSignal = ex;
    tif.PC_E         = pc;
    tif.DM_addr      = addr;
    tif.eret         = er;
    sb_q.push_back(e);
    tag_q.push_back(vec);
    vec++;
  endtask

  task automatic idle(input logic er, input obs_t e);
    cyc(1'b0, 1'b0, 7'd0, 64'd0, 64'd0, er, e);
  endtask

  // Monitor: compares every observed cycle against the scoreboard head.
  always @(negedge clk) begin
    obs_t e;
    obs_t a;
    int   t;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      t = tag_q.pop_front();
      a = mk(tif.flush, tif.redirect_en, tif.redirect_pc, tif.in_handler,
             tif.halted, tif.epc, tif.cause, tif.tval);
      checks++;
      if (a !== e) begin
        failures++;
        $display("FAIL vec%0d got flush=%b ren=%b rpc=%h inh=%b halt=%b epc=%h cause=%0d tval=%h | want flush=%b ren=%b rpc=%h inh=%b halt=%b epc=%h cause=%0d tval=%h",
                 t, a.flush, a.ren, a.rpc, a.inh, a.halt, a.epc, a.cause, a.tval,
                 e.flush, e.ren, e.rpc, e.inh, e.halt, e.epc, e.cause, e.tval);
      end
    end
  end

  initial begin
    reset            = 1'b1;
    tif.valid_E      = 1'b0;
    tif.exceptSignal = 7'd0;
    tif.PC_E         = 64'd0;
    tif.DM_addr      = 64'd0;
    tif.eret         = 1'b0;
    @(posedge clk);
    // Reset held, exception presented: flush stays low, state cleared.
    cyc(1, 1, 7'h7F, 64'h10, 64'h20, 0, mk(0, 0, 0, 0, 0, 0, 0, 0));

    // Read misalign
    cyc(0, 1, 7'b0000001, 64'h40, 64'h1003, 0, mk(1, 0, 0, 0, 0, 0, 0, 0));
    idle(0, mk(1, 1, TV, 0, 0, 64'h40, 4, 64'h1003));
    idle(0, mk(0, 0, 0, 1, 0, 64'h40, 4, 64'h1003));
    idle(1, mk(0, 0, 0, 1, 0, 64'h40, 4, 64'h1003));
    idle(0, mk(1, 1, 64'h40, 1, 0, 64'h40, 4, 64'h1003));
    idle(0, mk(0, 0, 0, 0, 0, 64'h40, 4, 64'h1003));
    // Stray eret in IDLE, then invalid instruction with all bits set
    idle(1, mk(0, 0, 0, 0, 0, 64'h40, 4, 64'h1003));
    idle(0, mk(0, 0, 0, 0, 0, 64'h40, 4, 64'h1003));
    cyc(0, 0, 7'h7F, 64'h80, 64'h90, 0, mk(0, 0, 0, 0, 0, 64'h40, 4, 64'h1003));
    idle(0, mk(0, 0, 0, 0, 0, 64'h40, 4, 64'h1003));

    // Breakpoint + write misalign together: breakpoint wins
    cyc(0, 1, 7'b1000100, 64'h200, 64'h3000, 0, mk(1, 0, 0, 0, 0, 64'h40, 4, 64'h1003));
    idle(0, mk(1, 1, TV, 0, 0, 64'h200, 3, 64'h200));
    idle(1, mk(0, 0, 0, 1, 0, 64'h200, 3, 64'h200));
    idle(0, mk(1, 1, 64'h204, 1, 0, 64'h200, 3, 64'h200));
    idle(0, mk(0, 0, 0, 0, 0, 64'h200, 3, 64'h200));

    // Write misalign, return to epc
    cyc(0, 1, 7'b0000100, 64'h500, 64'h6006, 0, mk(1, 0, 0, 0, 0, 64'h200, 3, 64'h200));
    idle(0, mk(1, 1, TV, 0, 0, 64'h500, 6, 64'h6006));
    idle(1, mk(0, 0, 0, 1, 0, 64'h500, 6, 64'h6006));
    idle(0, mk(1, 1, 64'h500, 1, 0, 64'h500, 6, 64'h6006));
    idle(0, mk(0, 0, 0, 0, 0, 64'h500, 6, 64'h6006));

    // Read PF + write AF + read AF: read PF wins; then double fault with eret
    cyc(0, 1, 7'b0011010, 64'h700, 64'h8000, 0, mk(1, 0, 0, 0, 0, 64'h500, 6, 64'h6006));
    idle(0, mk(1, 1, TV, 0, 0, 64'h700, 13, 64'h8000));
    cyc(0, 1, 7'b0100000, 64'h900, 64'hA000, 1, mk(1, 0, 0, 1, 0, 64'h700, 13, 64'h8000));
    idle(0, mk(1, 0, 0, 1, 1, 64'h700, 13, 64'h8000));
    cyc(0, 1, 7'b0000001, 64'h40, 64'h40, 1, mk(1, 0, 0, 1, 1, 64'h700, 13, 64'h8000));
    cyc(1, 0, 7'd0, 64'd0, 64'd0, 0, mk(0, 0, 0, 1, 1, 64'h700, 13, 64'h8000));
    idle(0, mk(0, 0, 0, 0, 0, 0, 0, 0));

    // Reset during ENTER aborts the redirect
    cyc(0, 1, 7'b0001000, 64'hA00, 64'hB000, 0, mk(1, 0, 0, 0, 0, 0, 0, 0));
    cyc(1, 0, 7'd0, 64'd0, 64'd0, 0, mk(0, 1, TV, 0, 0, 64'hA00, 7, 64'hB000));
    idle(0, mk(0, 0, 0, 0, 0, 0, 0, 0));
    idle(0, mk(0, 0, 0, 0, 0, 0, 0, 0));

    // Breakpoint at top of address space: epc+4 wraps to 0
    cyc(0, 1, 7'b1000000, 64'hFFFF_FFFF_FFFF_FFFC, 64'h1234, 0, mk(1, 0, 0, 0, 0, 0, 0, 0));
    idle(0, mk(1, 1, TV, 0, 0, 64'hFFFF_FFFF_FFFF_FFFC, 3, 64'hFFFF_FFFF_FFFF_FFFC));
    idle(1, mk(0, 0, 0, 1, 0, 64'hFFFF_FFFF_FFFF_FFFC, 3, 64'hFFFF_FFFF_FFFF_FFFC));
    idle(0, mk(1, 1, 64'h0, 1, 0, 64'hFFFF_FFFF_FFFF_FFFC, 3, 64'hFFFF_FFFF_FFFF_FFFC));
    idle(0, mk(0, 0, 0, 0, 0, 64'hFFFF_FFFF_FFFF_FFFC, 3, 64'hFFFF_FFFF_FFFF_FFFC));

    // Write AF beats read AF
    cyc(0, 1, 7'b0001010, 64'hC00, 64'hD000, 0, mk(1, 0, 0, 0, 0, 64'hFFFF_FFFF_FFFF_FFFC, 3, 64'hFFFF_FFFF_FFFF_FFFC));
    idle(0, mk(1, 1, TV, 0, 0, 64'hC00, 7, 64'hD000));
    idle(1, mk(0, 0, 0, 1, 0, 64'hC00, 7, 64'hD000));
    idle(0, mk(1, 1, 64'hC00, 1, 0, 64'hC00, 7, 64'hD000));
    idle(0, mk(0, 0, 0, 0, 0, 64'hC00, 7, 64'hD000));

    // Read access fault alone
    cyc(0, 1, 7'b0000010, 64'hE00, 64'hF00, 0, mk(1, 0, 0, 0, 0, 64'hC00, 7, 64'hD000));
    idle(0, mk(1, 1, TV, 0, 0, 64'hE00, 5, 64'hF00));
    idle(0, mk(0, 0, 0, 1, 0, 64'hE00, 5, 64'hF00));

    for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(posedge clk);
    @(posedge clk);
    if (sb_q.size() > 0) begin
      failures++;
      $display("FAIL drain got pending=%0d want pending=0", sb_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
